// File: rtl/d_sram_like_bridge.sv
// Bridges the CPU data-side SRAM port onto the sram-like req/addr_ok/data_ok bus,
// stalling the pipeline until each access completes and holding the read result.
module d_sram_like_bridge #(
  parameter logic KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        cpu_longest_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [3:0]  data_wen,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic [31:0] data_rdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_rdata;
  logic        w_kseg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      // Captured on every completion, writes included.
      if (r_state == S_WAIT && data_data_ok) begin
        r_rdata <= data_rdata;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cpu_en) begin
          w_next = data_addr_ok ? S_WAIT : S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (data_data_ok) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!cpu_longest_stall) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request and stall are suppressed while reset is held so nothing leaks onto the bus.
  assign data_req  = !rst && ((r_state == S_IDLE && cpu_en) || r_state == S_REQ);
  assign cpu_stall = !rst && cpu_en && (r_state != S_DONE);
  assign cpu_rdata = r_rdata;

  assign w_kseg     = KSEG_MAP && (cpu_addr[31:30] == 2'b10);
  assign data_addr  = w_kseg ? {3'b000, cpu_addr[28:0]} : cpu_addr;
  assign data_wr    = |cpu_wen;
  assign data_wen   = cpu_wen;
  assign data_size  = cpu_size;
  assign data_wdata = cpu_wdata;

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Randomised bench for d_sram_like_bridge: an access-level model predicts req/stall
// timing, bus fields and read-data holding from addr_ok/data_ok latencies.
module tb_d_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longest_stall;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;

  logic [31:0] cpu_rdata, cpu_rdata0;
  logic        cpu_stall, cpu_stall0;
  logic        data_req, data_req0;
  logic        data_wr, data_wr0;
  logic [1:0]  data_size, data_size0;
  logic [3:0]  data_wen, data_wen0;
  logic [31:0] data_addr, data_addr0;
  logic [31:0] data_wdata, data_wdata0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  d_sram_like_bridge #(.KSEG_MAP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .cpu_longest_stall(cpu_longest_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  d_sram_like_bridge #(.KSEG_MAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0),
    .cpu_stall(cpu_stall0), .cpu_longest_stall(cpu_longest_stall),
    .data_req(data_req0), .data_wr(data_wr0), .data_size(data_size0), .data_wen(data_wen0),
    .data_addr(data_addr0), .data_wdata(data_wdata0), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] map_addr(input logic [31:0] a);
    // kseg0 (0x8..0x9) and kseg1 (0xA..0xB) both land in physical low 512MB
    if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a - (a & 32'hE000_0000);
    return a;
  endfunction

  // One access: addr_ok arrives after a cycles, data_ok d cycles into the data phase,
  // and the pipeline stays frozen for lx extra cycles after completion.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] wen,
                            input logic [1:0] size, input logic [31:0] wd,
                            input logic [31:0] rd, input int a, input int d,
                            input int lx, input bit stray);
    int stall_len = a + d + 2;
    for (int k = 0; k <= stall_len + lx; k++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      cpu_en = 1'b1; cpu_addr = addr; cpu_wen = wen; cpu_size = size; cpu_wdata = wd;
      cpu_longest_stall = (k < stall_len + lx);
      data_addr_ok = (k == a);
      data_data_ok = (k == a + 1 + d);
      data_rdata   = data_data_ok ? rd : $urandom;
      if (stray && k > a && k <= a + d) data_addr_ok = 1'($urandom_range(0, 1));
      if (stray && k >= stall_len) begin
        data_addr_ok = 1'($urandom_range(0, 1));
        data_data_ok = 1'($urandom_range(0, 1));
      end
      #1;
      check("req", {31'b0, data_req}, {31'b0, k <= a});
      check("stall", {31'b0, cpu_stall}, {31'b0, k < stall_len});
      if (k <= a) begin
        check("addr", data_addr, map_addr(addr));
        check("addr_nomap", data_addr0, addr);
        check("wr", {31'b0, data_wr}, {31'b0, wen != 4'b0});
        check("wen", {28'b0, data_wen}, {28'b0, wen});
        check("size", {30'b0, data_size}, {30'b0, size});
        check("wdata", data_wdata, wd);
      end
      check("rdata", cpu_rdata, (k < stall_len) ? exp_rdata : rd);
    end
    exp_rdata = rd;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cpu_en = 1'b0; cpu_longest_stall = 1'b0;
      data_addr_ok = 1'($urandom_range(0, 1));
      data_data_ok = 1'($urandom_range(0, 1));
      data_rdata = $urandom;
      #1;
      check("idle_req", {31'b0, data_req}, 32'd0);
      check("idle_stall", {31'b0, cpu_stall}, 32'd0);
      check("idle_rdata", cpu_rdata, exp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b1; cpu_wen = '0; cpu_size = 2'd2; cpu_addr = 32'hBFC0_0000;
    cpu_wdata = '0; cpu_longest_stall = 1'b0; data_rdata = '0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    exp_rdata = '0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check("rst_req", {31'b0, data_req}, 32'd0);
      check("rst_stall", {31'b0, cpu_stall}, 32'd0);
    end
    check("rst_rdata", cpu_rdata, 32'd0);

    // Directed: read with data_ok two cycles after request, 3-cycle stall
    run_access(32'hBFC0_0000, 4'b0000, 2'd2, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 1'b0);
    check("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
    gap(1);
    // Directed: halfword write, addr_ok delayed 3 cycles
    run_access(32'h9000_1234, 4'b0011, 2'd1, 32'hCAFE_F00D, 32'h1111_2222, 3, 2, 0, 1'b0);
    gap(1);
    // Directed: completion under a long freeze with stray handshakes
    run_access(32'h0040_0100, 4'b0000, 2'd2, 32'h0, 32'h5A5A_A5A5, 1, 0, 5, 1'b1);
    // Directed: back-to-back reads, no gap
    run_access(32'hA000_0040, 4'b0000, 2'd2, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 1'b0);
    run_access(32'hA000_0044, 4'b0000, 2'd2, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b0);
    // Directed: unmapped instance passes kseg0 address unchanged
    run_access(32'h8000_0010, 4'b1111, 2'd2, 32'h7777_7777, 32'h8888_8888, 2, 0, 0, 1'b0);
    check("t6_nomap", data_addr0, 32'h8000_0010);

    // Reset while in the data phase
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_addr = 32'h0000_0200; cpu_wen = '0; data_addr_ok = 1'b1;
    data_data_ok = 1'b0; cpu_longest_stall = 1'b1;
    #1; check("r5_req0", {31'b0, data_req}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; data_addr_ok = 1'b0;
    #1;
    check("r5_req_rst", {31'b0, data_req}, 32'd0);
    check("r5_stall_rst", {31'b0, cpu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
    #1;
    check("r5_req", {31'b0, data_req}, 32'd0);
    check("r5_stall", {31'b0, cpu_stall}, 32'd0);
    check("r5_rdata", cpu_rdata, 32'd0);
    exp_rdata = '0;
    gap(1);
    run_access(32'hBFC0_0008, 4'b0000, 2'd2, 32'h0, 32'h0F0F_0F0F, 1, 1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr;
      addr = $urandom;
      addr[31:29] = 3'($urandom_range(0, 7));
      run_access(addr, 4'($urandom), 2'($urandom_range(0, 2)), $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 4),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 1'($urandom));
      gap($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
